// File: rtl/air_hockey_pkg.sv
// air_hockey_pkg: shared geometry, colours, signed limits and FSM states for the air hockey blocks
package air_hockey_pkg;
  localparam int WIDTH       = 96;
  localparam int HEIGHT      = 64;
  localparam int BORDER      = 3;
  localparam int PADDLE_H    = 14;
  localparam int PUCK_R      = 1;
  localparam int SERVE_TICKS = 32;
  localparam int GOAL_TICKS  = 48;
  localparam int WIN_SCORE   = 7;
  localparam logic [15:0] RED   = 16'hF800;
  localparam logic [15:0] BLUE  = 16'h001F;
  localparam logic [15:0] WHITE = 16'hFFFF;
  typedef logic signed [7:0] s8_t;
  typedef enum logic [1:0] {SERVE, PLAY, GOAL, GAMEOVER} state_t;
  localparam s8_t R_S       = s8_t'(PUCK_R);
  localparam s8_t Y_MIN     = s8_t'(PUCK_R);
  localparam s8_t Y_MAX     = s8_t'(HEIGHT - 1 - PUCK_R);
  localparam s8_t X_GOAL    = s8_t'(WIDTH - 1 - PUCK_R);
  localparam s8_t USER_LIM  = s8_t'(BORDER + 1 + PUCK_R);
  localparam s8_t AUDIO_LIM = s8_t'(WIDTH - BORDER - 2 - PUCK_R);
  localparam s8_t USER_REB  = s8_t'(BORDER + 2 + PUCK_R);
  localparam s8_t AUDIO_REB = s8_t'(WIDTH - BORDER - 3 - PUCK_R);
  localparam s8_t REACH     = s8_t'(PADDLE_H / 2 + PUCK_R);
  localparam s8_t QTR       = s8_t'((PADDLE_H / 2 + PUCK_R) / 2);
  localparam s8_t CX        = s8_t'(WIDTH / 2);
  localparam s8_t CY        = s8_t'(HEIGHT / 2);
endpackage

// File: rtl/air_hockey_puck_if.sv
// air_hockey_puck_if: paddle/pixel inputs and puck/score outputs of the puck engine
interface air_hockey_puck_if;
  logic        start;
  logic [6:0]  userPaddleY;
  logic [6:0]  audioPaddleY;
  logic [6:0]  x;
  logic [6:0]  y;
  logic [6:0]  puckX;
  logic [6:0]  puckY;
  logic        puckAppear;
  logic [15:0] puck_col;
  logic [3:0]  userScore;
  logic [3:0]  audioScore;
  logic        gameOver;
  logic        userWins;
  modport master (output start, userPaddleY, audioPaddleY, x, y,
                  input puckX, puckY, puckAppear, puck_col, userScore, audioScore, gameOver, userWins);
  modport slave  (input start, userPaddleY, audioPaddleY, x, y,
                  output puckX, puckY, puckAppear, puck_col, userScore, audioScore, gameOver, userWins);
endinterface

// File: rtl/puck_paddle_hit.sv
// puck_paddle_hit: geometric paddle contact test and rebound vy chosen by hit quarter
module puck_paddle_hit
  import air_hockey_pkg::*;
(
  input  s8_t        nx,
  input  s8_t        ny,
  input  logic [6:0] paddle_y,
  input  logic       side,
  output logic       hit,
  output s8_t        vy_new
);
  s8_t d;
  always_comb begin
    d      = ny - s8_t'({1'b0, paddle_y});
    hit    = (side ? nx >= AUDIO_LIM : nx <= USER_LIM) && d < REACH && d > -REACH;
    vy_new = d <= -QTR ? -8'sd2 : d < 8'sd0 ? -8'sd1 : d < QTR ? 8'sd1 : 8'sd2;
  end
endmodule

// File: rtl/air_hockey_puck.sv
// air_hockey_puck: puck motion, wall/paddle bounces, goals, scoring and serve/goal/game-over sequencing
module air_hockey_puck
  import air_hockey_pkg::*;
(
  input logic clkPuck,
  input logic rst,
  air_hockey_puck_if.slave bus
);
  state_t     state_q, state_d;
  s8_t        px_q, px_d, py_q, py_d, vx_q, vx_d, vy_q, vy_d;
  logic [5:0] cnt_q, cnt_d;
  logic [3:0] us_q, us_d, as_q, as_d;
  logic       game_over_q, game_over_d, user_wins_q, user_wins_d;
  s8_t        nx, ny0, ny, vy_w, u_vy, a_vy, xs, ys;
  logic       wall, u_geo, a_geo, u_hit, a_hit, goal_a, goal_u;

  puck_paddle_hit u_user  (.nx(nx), .ny(ny), .paddle_y(bus.userPaddleY),  .side(1'b0), .hit(u_geo), .vy_new(u_vy));
  puck_paddle_hit u_audio (.nx(nx), .ny(ny), .paddle_y(bus.audioPaddleY), .side(1'b1), .hit(a_geo), .vy_new(a_vy));

  always_comb begin
    nx     = px_q + vx_q;
    ny0    = py_q + vy_q;
    wall   = ny0 <= Y_MIN || ny0 >= Y_MAX;
    ny     = ny0 <= Y_MIN ? Y_MIN : ny0 >= Y_MAX ? Y_MAX : ny0;
    vy_w   = wall ? -vy_q : vy_q;
    u_hit  = u_geo && vx_q < 8'sd0;
    a_hit  = a_geo && vx_q > 8'sd0;
    goal_a = !u_hit && !a_hit && nx <= R_S;
    goal_u = !u_hit && !a_hit && nx >= X_GOAL;
  end

  always_comb begin
    state_d     = state_q;
    px_d        = px_q;
    py_d        = py_q;
    vx_d        = vx_q;
    vy_d        = vy_q;
    cnt_d       = cnt_q;
    us_d        = us_q;
    as_d        = as_q;
    game_over_d = game_over_q;
    user_wins_d = user_wins_q;
    unique case (state_q)
      SERVE: begin
        cnt_d   = cnt_q == 6'(SERVE_TICKS - 1) ? 6'd0 : cnt_q + 6'd1;
        state_d = cnt_q == 6'(SERVE_TICKS - 1) ? PLAY : SERVE;
      end
      PLAY: begin
        px_d    = u_hit ? USER_REB : a_hit ? AUDIO_REB : nx;
        py_d    = ny;
        vx_d    = u_hit ? 8'sd1 : a_hit ? -8'sd1 : vx_q;
        vy_d    = u_hit ? u_vy : a_hit ? a_vy : vy_w;
        as_d    = goal_a && as_q != 4'(WIN_SCORE) ? as_q + 4'd1 : as_q;
        us_d    = goal_u && us_q != 4'(WIN_SCORE) ? us_q + 4'd1 : us_q;
        state_d = goal_a || goal_u ? GOAL : PLAY;
      end
      GOAL: begin
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(GOAL_TICKS - 1)) begin
          cnt_d = 6'd0;
          if (us_q == 4'(WIN_SCORE) || as_q == 4'(WIN_SCORE)) begin
            state_d     = GAMEOVER;
            game_over_d = 1'b1;
            user_wins_d = us_q == 4'(WIN_SCORE);
          end else begin
            // the frozen puck sits on the conceding side, so serve back toward it
            state_d = SERVE;
            vx_d    = px_q < CX ? -8'sd1 : 8'sd1;
            vy_d    = 8'sd1;
            px_d    = CX;
            py_d    = CY;
          end
        end
      end
      GAMEOVER: begin
        if (bus.start) begin
          state_d     = SERVE;
          px_d        = CX;
          py_d        = CY;
          vx_d        = 8'sd1;
          vy_d        = 8'sd1;
          us_d        = 4'd0;
          as_d        = 4'd0;
          game_over_d = 1'b0;
          user_wins_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clkPuck or posedge rst) begin
    if (rst) begin
      state_q     <= SERVE;
      px_q        <= CX;
      py_q        <= CY;
      vx_q        <= 8'sd1;
      vy_q        <= 8'sd1;
      cnt_q       <= 6'd0;
      us_q        <= 4'd0;
      as_q        <= 4'd0;
      game_over_q <= 1'b0;
      user_wins_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      px_q        <= px_d;
      py_q        <= py_d;
      vx_q        <= vx_d;
      vy_q        <= vy_d;
      cnt_q       <= cnt_d;
      us_q        <= us_d;
      as_q        <= as_d;
      game_over_q <= game_over_d;
      user_wins_q <= user_wins_d;
    end
  end

  always_comb begin
    xs             = s8_t'({1'b0, bus.x});
    ys             = s8_t'({1'b0, bus.y});
    bus.puckAppear = xs >= px_q - R_S && xs <= px_q + R_S && ys >= py_q - R_S && ys <= py_q + R_S;
  end

  assign bus.puckX      = px_q[6:0];
  assign bus.puckY      = py_q[6:0];
  assign bus.puck_col   = WHITE;
  assign bus.userScore  = us_q;
  assign bus.audioScore = as_q;
  assign bus.gameOver   = game_over_q;
  assign bus.userWins   = user_wins_q;
endmodule

// File: tb/tb_air_hockey_puck.sv
// tb_air_hockey_puck: directed trajectory, bounce, goal, game-over and reset checks for air_hockey_puck
module tb_air_hockey_puck;
  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_pass = 0;

  air_hockey_puck_if bus ();
  air_hockey_puck dut (.clkPuck(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pos(input string tag, input int ex, input int ey);
    check({tag, ".x"}, 32'(bus.puckX), 32'(ex));
    check({tag, ".y"}, 32'(bus.puckY), 32'(ey));
  endtask

  task automatic pulse_rst();
    #2 rst = 1'b1;
    #1;
    pos("rst_mid", 48, 32);
    check("rst_mid.us", 32'(bus.userScore), 0);
    check("rst_mid.as", 32'(bus.audioScore), 0);
    check("rst_mid.go", 32'(bus.gameOver), 0);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.userPaddleY = 7'd12;
    bus.audioPaddleY = 7'd50;
    bus.x = 7'd0;
    bus.y = 7'd0;
    tick(2);
    rst = 1'b0;
    pos("reset", 48, 32);
    check("reset.us", 32'(bus.userScore), 0);
    check("reset.as", 32'(bus.audioScore), 0);
    check("reset.go", 32'(bus.gameOver), 0);
    check("reset.uw", 32'(bus.userWins), 0);
    check("col", 32'(bus.puck_col), 32'hFFFF);
    bus.x = 7'd47; bus.y = 7'd33; #1 check("appear_in_corner", 32'(bus.puckAppear), 1);
    bus.x = 7'd50; bus.y = 7'd32; #1 check("appear_out_x", 32'(bus.puckAppear), 0);
    bus.x = 7'd49; bus.y = 7'd31; #1 check("appear_in_edge", 32'(bus.puckAppear), 1);
    bus.x = 7'd48; bus.y = 7'd34; #1 check("appear_out_y", 32'(bus.puckAppear), 0);
    tick(32);  pos("serve_hold", 48, 32);
    tick(1);   pos("play1", 49, 33);
    tick(28);  pos("near_bottom", 77, 61);
    tick(1);   pos("bottom_clamp", 78, 62);
    tick(1);   pos("after_bottom", 79, 61);
    tick(11);  pos("audio_hit", 89, 50);
    tick(1);   pos("after_audio", 88, 51);
    tick(82);  pos("near_user", 6, 11);
    tick(1);   pos("user_hit", 6, 12);
    check("user_hit.as", 32'(bus.audioScore), 0);
    tick(1);   pos("after_user", 7, 13);
    bus.userPaddleY = 7'd127;
    pulse_rst();
    tick(157); pos("b_near_user", 6, 11);
    tick(1);   pos("b_miss", 5, 12);
    tick(3);   pos("b_pre_goal", 2, 15);
    check("b_pre_goal.as", 32'(bus.audioScore), 0);
    tick(1);   pos("b_goal", 1, 16);
    check("b_goal.as", 32'(bus.audioScore), 1);
    check("b_goal.us", 32'(bus.userScore), 0);
    tick(47);  pos("b_frozen", 1, 16);
    tick(1);   pos("b_recentre", 48, 32);
    tick(32);  pos("b_serve", 48, 32);
    tick(1);   pos("b_serve_left", 47, 33);
    bus.audioPaddleY = 7'd127;
    pulse_rst();
    for (int g = 1; g <= 7; g++) begin
      tick(78);
      pos($sformatf("c_goal%0d", g), 94, 46);
      check($sformatf("c_goal%0d.us", g), 32'(bus.userScore), 32'(g));
      check($sformatf("c_goal%0d.go", g), 32'(bus.gameOver), 0);
      tick(48);
    end
    check("over.go", 32'(bus.gameOver), 1);
    check("over.uw", 32'(bus.userWins), 1);
    check("over.us", 32'(bus.userScore), 7);
    check("over.as", 32'(bus.audioScore), 0);
    tick(5);   pos("over_frozen", 94, 46);
    check("over_hold.go", 32'(bus.gameOver), 1);
    bus.start = 1'b1;
    tick(1);   pos("restart", 48, 32);
    check("restart.go", 32'(bus.gameOver), 0);
    check("restart.us", 32'(bus.userScore), 0);
    check("restart.uw", 32'(bus.userWins), 0);
    tick(32);  pos("restart_serve", 48, 32);
    tick(1);   pos("restart_play", 49, 33);
    bus.start = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
